// File: rtl/axi_lite_datmem_slave.sv
// AXI4-Lite slave backed by a word array with byte-strobed writes.
// Write and read channels run as independent FSMs; one transaction
// outstanding per channel. Reads return after RD_WAIT extra cycles.
module axi_lite_datmem_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_WAIT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // Below-base addresses fail the first term; the shifted offset is the word index.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        wr_commit, wr_ok;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write next-state, readies, and the commit address/data mux (live or held half)
    always_comb begin
        w_next    = w_state;
        awready   = 1'b0;
        wready    = 1'b0;
        wr_commit = 1'b0;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) begin
                    w_next    = W_RESP;
                    wr_commit = 1'b1;
                    wr_addr   = awaddr;
                    wr_data   = wdata;
                    wr_strb   = wstrb;
                end else if (awvalid) begin
                    w_next = W_WAIT_W;
                end else if (wvalid) begin
                    w_next = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_next    = W_RESP;
                    wr_commit = 1'b1;
                    wr_data   = wdata;
                    wr_strb   = wstrb;
                end
            end
            W_WAIT_AW: begin
                awready = 1'b1;
                if (awvalid) begin
                    w_next    = W_RESP;
                    wr_commit = 1'b1;
                    wr_addr   = awaddr;
                end
            end
            W_RESP: begin
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        // Reset blocks handshakes and any pending commit combinationally.
        if (rst) begin
            awready   = 1'b0;
            wready    = 1'b0;
            wr_commit = 1'b0;
            w_next    = W_IDLE;
        end
    end

    assign wr_ok  = addr_ok(wr_addr);
    assign bvalid = (w_state == W_RESP);

    // Hold whichever half of the write arrives first
    always_ff @(posedge clk) begin
        if (awready && awvalid) aw_addr_q <= awaddr;
        if (wready && wvalid) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    // Response code is fixed at commit time and held through W_RESP
    always_ff @(posedge clk) begin
        if (rst)            bresp <= 2'b00;
        else if (wr_commit) bresp <= wr_ok ? 2'b00 : 2'b10;
    end

    // Array update: strobed byte lanes only, never on out-of-range addresses
    always_ff @(posedge clk) begin
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[addr_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [3:0]  rd_cnt;
    logic [31:0] ar_addr_q, rd_addr;
    logic        rd_sample;

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read next-state, arready, and the sample strobe for entering R_RESP
    always_comb begin
        r_next    = r_state;
        arready   = 1'b0;
        rd_sample = 1'b0;
        rd_addr   = ar_addr_q;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    if (RD_WAIT == 0) begin
                        r_next    = R_RESP;
                        rd_sample = 1'b1;
                        rd_addr   = araddr;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt <= 4'd1) begin
                    r_next    = R_RESP;
                    rd_sample = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
        if (rst) begin
            arready   = 1'b0;
            rd_sample = 1'b0;
            r_next    = R_IDLE;
        end
    end

    assign rvalid = (r_state == R_RESP);

    // Wait counter and read address capture
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= 4'd0;
        end else if (arready && arvalid) begin
            rd_cnt    <= 4'(RD_WAIT);
            ar_addr_q <= araddr;
        end else if (r_state == R_WAIT) begin
            rd_cnt <= rd_cnt - 4'd1;
        end
    end

    // Read data sample; a same-edge write is not visible (old word returned)
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
            rresp <= 2'b00;
        end else if (rd_sample) begin
            if (addr_ok(rd_addr)) begin
                rdata <= mem[addr_idx(rd_addr)];
                rresp <= 2'b00;
            end else begin
                rdata <= 32'h0;
                rresp <= 2'b10;
            end
        end
    end

endmodule

// File: doc/axi_lite_datmem_slave.md
AXI_LITE_DATMEM_SLAVE -- requirements
Module: axi_lite_datmem_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words held in the array.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 Parameter RD_WAIT, default 1, extra wait cycles (0..15) inserted before RVALID.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 awaddr  input  32  write address; awvalid input 1; awready output 1.
REQ-008 wdata  input  32  write data; wstrb input 4 byte strobes; wvalid input 1; wready output 1.
REQ-009 bresp  output  2  write response; bvalid output 1; bready input 1.
REQ-010 araddr  input  32  read address; arvalid input 1; arready output 1.
REQ-011 rdata  output  32  read data; rresp output 2; rvalid output 1; rready input 1.

Function
REQ-012 The write and read channels shall be served by two independent state machines that may be active in the same cycle.
REQ-013 The write FSM shall have states W_IDLE, W_WAIT_W (address held), W_WAIT_AW (data held) and W_RESP.
REQ-014 awready shall be 1 in W_IDLE and W_WAIT_AW only; wready shall be 1 in W_IDLE and W_WAIT_W only; both shall be 0 while rst=1.
REQ-015 In W_IDLE, AW-only handshake shall latch awaddr and go to W_WAIT_W; W-only handshake shall latch wdata/wstrb and go to W_WAIT_AW; both handshakes together shall go directly to W_RESP.
REQ-016 On the edge that enters W_RESP the write shall commit: each byte lane i with wstrb[i]=1 updated, lanes with wstrb[i]=0 unchanged; bvalid shall be 1 from the next cycle.
REQ-017 Word index shall be (awaddr-BASE_ADDR)>>2; awaddr[1:0] ignored.
REQ-018 An address below BASE_ADDR or with word index >= DEPTH_WORDS shall not modify the array and shall give bresp=2'b10 (SLVERR); otherwise bresp=2'b00 (OKAY).
REQ-019 bvalid and bresp shall stay stable until bvalid&bready; W_RESP shall then return to W_IDLE, with awready/wready high the following cycle.
REQ-020 Latency: simultaneous AW+W handshake in cycle N shall give bvalid=1 in cycle N+1.
REQ-021 The read FSM shall have states R_IDLE, R_WAIT and R_RESP; arready shall be 1 only in R_IDLE and rst=0.
REQ-022 On an AR handshake a 4-bit counter shall load RD_WAIT and araddr shall be latched; if RD_WAIT=0 the next state shall be R_RESP, else R_WAIT.
REQ-023 In R_WAIT the counter shall decrement each cycle; when it reaches 1 the next state shall be R_RESP.
REQ-024 rdata shall be sampled from the array on the edge that enters R_RESP; rvalid shall be 1 exactly RD_WAIT+1 cycles after the AR handshake cycle.
REQ-025 Out-of-range read shall return rdata=32'h0 and rresp=2'b10; in-range read rresp=2'b00.
REQ-026 rvalid, rdata, rresp shall stay stable until rvalid&rready; R_RESP shall then return to R_IDLE.
REQ-027 If a write commit and a read sample occur on the same edge to the same word, the read shall return pre-write data.
REQ-028 At most one outstanding transaction per channel; no new AW/W/AR shall be accepted while its FSM is busy.

Reset
REQ-029 While rst=1 at a clock edge both FSMs shall enter their IDLE state, counter=0, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=32'h0.
REQ-030 Reset mid-transaction shall abandon it; a write not yet committed shall not modify the array.
REQ-031 Array contents shall not be cleared by reset.

Verification
REQ-032 AW+W same cycle, addr 0x10, data 0xDEADBEEF, strb 4'hF, bready=1 -> bvalid next cycle, bresp=00; read 0x10 with RD_WAIT=1 -> rvalid 2 cycles after AR, rdata=0xDEADBEEF.
REQ-033 W first, AW three cycles later, addr 0x10 data 0x00000011 strb 4'b0001 -> bresp=00; readback 0xDEADBE11.
REQ-034 Write addr BASE_ADDR+4*DEPTH_WORDS -> bresp=10, array unchanged; read same -> rresp=10, rdata=0.
REQ-035 Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and payloads stable; awready/wready/arready stay 0.
REQ-036 Assert rst during R_WAIT and during W_WAIT_W -> next cycle rvalid=0, bvalid=0, all readies 1 after rst drops, target word unchanged.
REQ-037 Write commit and read sample on same edge to 0x20 (old 0x1, new 0x2) -> rdata=0x1; a later read returns 0x2.
